// File: rtl/mem_io_responder.sv
// Byte-wide memory bus target: RAM plus a memory-mapped UART TX/RX window.
// Read data and the TX-almost-full flag are registered, so reads have one cycle of latency.
module mem_io_responder #(
  parameter int RAM_ADDR_WIDTH = 16,
  parameter int TX_FIFO_DEPTH  = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic        uart_tx_valid,
  output logic [7:0]  uart_tx_data,
  input  logic        uart_tx_ready,
  input  logic        uart_rx_valid,
  input  logic [7:0]  uart_rx_data,
  output logic        uart_rx_ack,
  output logic        tx_overflow,
  output logic        sim_halt
);
  localparam int PW = $clog2(TX_FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [7:0] ram [2**RAM_ADDR_WIDTH];
  logic [7:0] fifo_q [TX_FIFO_DEPTH];

  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    din_q, din_d;
  logic          ack_q, ack_d;
  logic          full_q, ovf_q, halt_q;

  logic                      io, data_sel, ctrl_sel, rd_en, wr_en;
  logic                      push_req, push, pop, fifo_full;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr;
  logic                      unused_addr;

  // Upper address bits above the decode/RAM window are don't-care.
  assign unused_addr = ^mem_a;

  assign io       = (mem_a[17:16] == 2'b11);
  assign data_sel = io && (mem_a[15:0] == 16'h0000);
  assign ctrl_sel = io && (mem_a[15:0] == 16'h0004);
  assign rd_en    = rdy_in && !mem_wr;
  assign wr_en    = rdy_in && mem_wr;
  assign ram_addr = mem_a[RAM_ADDR_WIDTH-1:0];

  // A full FIFO drops the push even if a pop happens in the same cycle.
  assign fifo_full = (count_q == CW'(TX_FIFO_DEPTH));
  assign push_req  = wr_en && data_sel;
  assign push      = push_req && !fifo_full;
  assign pop       = uart_tx_valid && uart_tx_ready;
  assign count_d   = count_q + CW'(push) - CW'(pop);

  assign uart_tx_valid  = (count_q != '0);
  // Head byte is masked while empty so the FIFO storage needs no reset.
  assign uart_tx_data   = uart_tx_valid ? fifo_q[head_q] : 8'h00;
  assign mem_din        = din_q;
  assign uart_rx_ack    = ack_q;
  assign io_buffer_full = full_q;
  assign tx_overflow    = ovf_q;
  assign sim_halt       = halt_q;

  // Read-data mux: RAM, UART RX byte, status, or zero for unmapped IO.
  always_comb begin
    din_d = 8'h00;
    ack_d = 1'b0;
    if (!io) begin
      din_d = ram[ram_addr];
    end else if (data_sel) begin
      if (uart_rx_valid) begin
        din_d = uart_rx_data;
        ack_d = rd_en;
      end
    end else if (ctrl_sel) begin
      din_d = {6'b0, uart_rx_valid, full_q};
    end
  end

  // RAM and FIFO storage: plain write ports, contents survive reset.
  always_ff @(posedge clk_in) begin
    if (wr_en && !io) ram[ram_addr] <= mem_dout;
    if (push)         fifo_q[tail_q] <= mem_dout;
  end

  // Control state: read data, ack pulse, FIFO pointers and sticky flags.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      din_q   <= 8'h00;
      ack_q   <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      if (rd_en) din_q <= din_d;
      ack_q   <= ack_d;
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d >= CW'(TX_FIFO_DEPTH - 2));
      if (push_req && fifo_full) ovf_q  <= 1'b1;
      if (wr_en && ctrl_sel)     halt_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: vector table, directed corner sequences and
// randomized traffic, all checked against a queue-based reference model.
module tb_mem_io_responder;
  localparam int DEPTH = 8;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b0;
  logic [31:0] mem_a = '0;
  logic        mem_wr = 1'b0;
  logic [7:0]  mem_dout = '0;
  logic        uart_tx_ready = 1'b0;
  logic        uart_rx_valid = 1'b0;
  logic [7:0]  uart_rx_data = '0;
  logic [7:0]  mem_din, uart_tx_data;
  logic        io_buffer_full, uart_tx_valid, uart_rx_ack, tx_overflow, sim_halt;

  mem_io_responder #(.RAM_ADDR_WIDTH(16), .TX_FIFO_DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .mem_a(mem_a),
    .mem_wr(mem_wr), .mem_dout(mem_dout), .mem_din(mem_din),
    .io_buffer_full(io_buffer_full), .uart_tx_valid(uart_tx_valid),
    .uart_tx_data(uart_tx_data), .uart_tx_ready(uart_tx_ready),
    .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data),
    .uart_rx_ack(uart_rx_ack), .tx_overflow(tx_overflow), .sim_halt(sim_halt)
  );

  always #5 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: byte map for RAM, queue for the TX FIFO.
  logic [7:0] m_ram [int];
  logic [7:0] m_q [$];
  logic [7:0] m_din;
  bit         m_ack, m_full, m_ovf, m_halt;

  typedef struct {
    bit          rdy;
    bit          wr;
    logic [31:0] a;
    logic [7:0]  d;
    logic [7:0]  exp_din;
  } vec_t;
  vec_t vt [$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_din = 8'h00; m_ack = 0; m_full = 0; m_ovf = 0; m_halt = 0;
  endtask

  // Apply the bus rules to the inputs present before the coming edge.
  task automatic model_edge();
    bit         io, pop, was_full, push_req;
    int         off, addr;
    logic [7:0] nd;
    bit         na;
    io   = (mem_a[17:16] == 2'b11);
    off  = int'(mem_a[15:0]);
    addr = int'(mem_a[15:0]);
    nd   = m_din;
    na   = 0;
    if (rdy_in && !mem_wr) begin
      if (!io) nd = m_ram.exists(addr) ? m_ram[addr] : 8'h00;
      else if (off == 0) begin
        nd = uart_rx_valid ? uart_rx_data : 8'h00;
        na = uart_rx_valid;
      end else if (off == 4) nd = {6'b0, uart_rx_valid, m_full};
      else nd = 8'h00;
    end
    if (rdy_in && mem_wr && !io) m_ram[addr] = mem_dout;
    if (rdy_in && mem_wr && io && off == 4) m_halt = 1;
    push_req = rdy_in && mem_wr && io && off == 0;
    pop      = (m_q.size() > 0) && uart_tx_ready;
    was_full = (m_q.size() == DEPTH);
    if (push_req && was_full) m_ovf = 1;
    if (pop) void'(m_q.pop_front());
    if (push_req && !was_full) m_q.push_back(mem_dout);
    m_full = (m_q.size() >= DEPTH - 2);
    m_din  = nd;
    m_ack  = na;
  endtask

  task automatic check_all();
    chk("din", mem_din, m_din);
    chk("rx_ack", uart_rx_ack, m_ack);
    chk("tx_valid", uart_tx_valid, m_q.size() != 0);
    chk("tx_data", uart_tx_data, (m_q.size() != 0) ? m_q[0] : 8'h00);
    chk("buf_full", io_buffer_full, m_full);
    chk("overflow", tx_overflow, m_ovf);
    chk("halt", sim_halt, m_halt);
  endtask

  task automatic drive(bit rdy, bit wr, logic [31:0] a, logic [7:0] d);
    rdy_in = rdy; mem_wr = wr; mem_a = a; mem_dout = d;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk_in);
    #1;
    check_all();
  endtask

  initial begin
    logic [31:0] ra;
    int          r;

    vt.push_back('{1, 1, 32'h0000_0100, 8'h78, 8'h00});
    vt.push_back('{1, 1, 32'h0000_0101, 8'h56, 8'h00});
    vt.push_back('{1, 1, 32'h0000_0102, 8'h34, 8'h00});
    vt.push_back('{1, 1, 32'h0000_0103, 8'h12, 8'h00});
    vt.push_back('{1, 0, 32'h0000_0100, 8'h00, 8'h78});
    vt.push_back('{1, 0, 32'h0000_0101, 8'h00, 8'h56});
    vt.push_back('{1, 0, 32'h0000_0102, 8'h00, 8'h34});
    vt.push_back('{1, 0, 32'h0000_0103, 8'h00, 8'h12});
    vt.push_back('{1, 0, 32'h0000_0100, 8'h00, 8'h78});
    vt.push_back('{0, 1, 32'h0000_0100, 8'hFF, 8'h78});
    vt.push_back('{0, 1, 32'h0000_0100, 8'hFF, 8'h78});
    vt.push_back('{0, 1, 32'h0000_0100, 8'hFF, 8'h78});
    vt.push_back('{1, 0, 32'h0000_0100, 8'h00, 8'h78});
    vt.push_back('{1, 0, 32'h0003_0008, 8'h00, 8'h00});
    vt.push_back('{1, 1, 32'h0003_0008, 8'h55, 8'h00});
    vt.push_back('{1, 1, 32'h0000_0000, 8'h9C, 8'h00});
    vt.push_back('{1, 0, 32'h0000_0000, 8'h00, 8'h9C});
    vt.push_back('{1, 0, 32'h0004_0100, 8'h00, 8'h78});
    vt.push_back('{1, 0, 32'h0001_0101, 8'h00, 8'h56});
    vt.push_back('{0, 0, 32'h0000_0000, 8'h00, 8'h56});

    // Reset state, asserted before any clock edge.
    model_reset();
    #2 rst_in = 1'b0;
    #1;
    chk("rst din", mem_din, 8'h00);
    chk("rst tx_valid", uart_tx_valid, 1'b0);
    check_all();
    @(posedge clk_in); #1;
    rst_in = 1'b1;

    // Vector table: RAM word, rdy gating, unmapped IO, aliasing.
    foreach (vt[i]) begin
      drive(vt[i].rdy, vt[i].wr, vt[i].a, vt[i].d);
      cycle();
      chk($sformatf("vec%0d din", i), mem_din, vt[i].exp_din);
      chk($sformatf("vec%0d tx_valid", i), uart_tx_valid, 1'b0);
    end

    // TX backpressure: fill, overflow, then drain in order.
    uart_tx_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      drive(1, 1, 32'h0003_0000, 8'h41 + 8'(k));
      cycle();
      chk($sformatf("bp full %0d", k), io_buffer_full, k >= 5);
      chk($sformatf("bp ovf %0d", k), tx_overflow, k == 8);
    end
    drive(0, 0, 32'h0, 8'h0);
    uart_tx_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain %0d", k), uart_tx_data, 8'h41 + 8'(k));
      cycle();
    end
    chk("drain empty", uart_tx_valid, 1'b0);

    // Push and pop in the same cycle at count 3.
    uart_tx_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 32'h0003_0000, 8'h10 + 8'(k));
      cycle();
    end
    uart_tx_ready = 1'b1;
    drive(1, 1, 32'h0003_0000, 8'h13);
    cycle();
    drive(0, 0, 32'h0, 8'h0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("pp order %0d", k), uart_tx_data, 8'h11 + 8'(k));
      cycle();
    end
    chk("pp empty", uart_tx_valid, 1'b0);

    // IO reads of RX data and status, control write.
    uart_tx_ready = 1'b0;
    uart_rx_valid = 1'b1; uart_rx_data = 8'h5A;
    drive(1, 0, 32'h0003_0000, 8'h0);
    cycle();
    chk("rx din", mem_din, 8'h5A);
    chk("rx ack", uart_rx_ack, 1'b1);
    drive(0, 0, 32'h0, 8'h0);
    cycle();
    chk("rx ack pulse", uart_rx_ack, 1'b0);
    uart_rx_valid = 1'b0;
    drive(1, 0, 32'h0003_0000, 8'h0);
    cycle();
    chk("rx empty din", mem_din, 8'h00);
    chk("rx empty ack", uart_rx_ack, 1'b0);
    for (int k = 0; k < 6; k++) begin
      drive(1, 1, 32'h0003_0000, 8'h60 + 8'(k));
      cycle();
    end
    uart_rx_valid = 1'b1;
    drive(1, 0, 32'h0003_0004, 8'h0);
    cycle();
    chk("status", mem_din, 8'h03);
    drive(1, 1, 32'h0003_0004, 8'hAB);
    cycle();
    chk("halt set", sim_halt, 1'b1);
    uart_rx_valid = 1'b0;
    uart_tx_ready = 1'b1;
    drive(0, 0, 32'h0, 8'h0);
    for (int k = 0; k < 6; k++) cycle();

    // Reset mid-stream with three bytes queued.
    uart_tx_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 32'h0003_0000, 8'h70 + 8'(k));
      cycle();
    end
    drive(0, 0, 32'h0, 8'h0);
    rst_in = 1'b0;
    #1;
    model_reset();
    chk("mid rst tx_valid", uart_tx_valid, 1'b0);
    chk("mid rst halt", sim_halt, 1'b0);
    chk("mid rst ovf", tx_overflow, 1'b0);
    check_all();
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    cycle();
    chk("post rst tx_valid", uart_tx_valid, 1'b0);

    // Randomized traffic over a small RAM window and the IO registers.
    for (int k = 0; k < 8; k++) begin
      drive(1, 1, 32'h200 + 32'(k), 8'($urandom()));
      cycle();
    end
    for (int n = 0; n < 800; n++) begin
      r = $urandom_range(0, 12);
      if (r < 8)        ra = 32'h200 + 32'(r);
      else if (r == 8)  ra = 32'h0;
      else if (r < 11)  ra = 32'h0003_0000;
      else if (r == 11) ra = 32'h0003_0004;
      else              ra = 32'h0003_0008;
      ra = ra | ($urandom() & 32'hFFFC_0000);
      drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), ra, 8'($urandom()));
      uart_tx_ready = ($urandom_range(0, 2) == 0);
      uart_rx_valid = 1'($urandom_range(0, 1));
      uart_rx_data  = 8'($urandom());
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
